// File: rtl/data_memory_dump_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_dump_ctrl
//   Debug-side sequencer that dumps the data memory over the UART TX path.
//   On a start request it walks the debug read pointer from word 0 up to
//   NUM_WORDS-1, waits READ_LATENCY cycles for each word to appear on the
//   debug read port, latches it, and streams it as four bytes (MSB first)
//   over a valid/ready handshake. A one-cycle done pulse closes the dump.
//
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_start        dump request, level-sampled only while idle
//   i_mem_data     word returned by the data memory debug read port
//   o_mem_pointer  word address driven to the data memory debug port
//   o_tx_data      byte presented to the UART transmitter
//   o_tx_valid     o_tx_data holds a byte to be transferred
//   i_tx_ready     UART transmitter can accept a byte
//   o_busy         dump in progress
//   o_done         one-cycle pulse after the last byte has been accepted
// -----------------------------------------------------------------------------
module data_memory_dump_ctrl #(
  parameter int TAM_DATA     = 32,
  parameter int NUM_DIREC    = 7,
  parameter int NUM_WORDS    = 128,
  parameter int READ_LATENCY = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [TAM_DATA-1:0]  i_mem_data,
  output logic [NUM_DIREC-1:0] o_mem_pointer,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [NUM_DIREC-1:0] LAST_PTR = NUM_DIREC'(NUM_WORDS - 1);
  localparam logic [NUM_DIREC-1:0] PTR_ONE  = NUM_DIREC'(1);
  // Counter value on the last ADDR cycle: after READ_LATENCY cycles the word
  // on i_mem_data belongs to the current pointer.
  localparam logic [2:0]           LAT_LAST = 3'(READ_LATENCY - 1);

  // Byte lane selection, index 0 is the most significant byte.
  function automatic logic [7:0] sel_byte(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [NUM_DIREC-1:0]   ptr_r, ptr_nxt_s;
  logic [7:0]             tx_data_r, tx_data_nxt_s;
  logic                   tx_valid_r, tx_valid_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic                   done_r, done_nxt_s;
  logic [TAM_DATA-1:0]    word_r, word_nxt_s;
  logic [1:0]             idx_r, idx_nxt_s;
  logic [2:0]             lat_r, lat_nxt_s;

  // Next-state and next-output computation for the dump sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    tx_data_nxt_s  = tx_data_r;
    tx_valid_nxt_s = tx_valid_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    word_nxt_s     = word_r;
    idx_nxt_s      = idx_r;
    lat_nxt_s      = lat_r;

    case (state_r)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        if (i_start) begin
          state_nxt_s = ST_ADDR;
          ptr_nxt_s   = '0;
          busy_nxt_s  = 1'b1;
          lat_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_ADDR: begin
        lat_nxt_s = lat_r + 3'd1;
        if (lat_r == LAT_LAST) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end

      ST_LOAD: begin
        word_nxt_s     = i_mem_data;
        idx_nxt_s      = 2'd0;
        tx_data_nxt_s  = sel_byte(i_mem_data, 2'd0);
        tx_valid_nxt_s = 1'b1;
        state_nxt_s    = ST_SEND;
      end

      ST_SEND: begin
        // Without a transfer everything holds, so valid never drops early
        // and the presented byte stays stable under backpressure.
        if (tx_valid_r && i_tx_ready) begin
          if (idx_r != 2'd3) begin
            idx_nxt_s     = idx_r + 2'd1;
            tx_data_nxt_s = sel_byte(word_r, idx_r + 2'd1);
          end else begin
            tx_valid_nxt_s = 1'b0;
            if (ptr_r == LAST_PTR) begin
              state_nxt_s = ST_DONE;
              done_nxt_s  = 1'b1;
            end else begin
              ptr_nxt_s   = ptr_r + PTR_ONE;
              lat_nxt_s   = 3'd0;
              state_nxt_s = ST_ADDR;
            end
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end

      ST_DONE: begin
        ptr_nxt_s   = '0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end

      default: begin
        state_nxt_s    = ST_IDLE;
        ptr_nxt_s      = '0;
        tx_data_nxt_s  = 8'd0;
        tx_valid_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
        word_nxt_s     = '0;
        idx_nxt_s      = 2'd0;
        lat_nxt_s      = 3'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in progress.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      word_r     <= '0;
      idx_r      <= 2'd0;
      lat_r      <= 3'd0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      word_r     <= word_nxt_s;
      idx_r      <= idx_nxt_s;
      lat_r      <= lat_nxt_s;
    end
  end

  assign o_mem_pointer = ptr_r;
  assign o_tx_data     = tx_data_r;
  assign o_tx_valid    = tx_valid_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;

endmodule

// File: tb/tb_data_memory_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_dump_ctrl
//   Scoreboard bench: expected bytes are queued when a dump is requested and
//   monitor processes pop/compare on every accepted byte. Instance A uses the
//   default parameters, instance B the NUM_WORDS=1 / READ_LATENCY=3 corner.
// -----------------------------------------------------------------------------
module tb_data_memory_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b;
  logic        tx_ready_a = 1'b0;
  logic        ready_b = 1'b1;
  logic [31:0] mem_data_a, mem_data_b;
  logic [6:0]  ptr_a, ptr_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

  logic [31:0] mem [0:127];
  logic [31:0] pipe_b1, pipe_b2, pipe_b3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_qb[$];
  int bytes_a = 0, done_cnt_a = 0;
  int bytes_b = 0, done_cnt_b = 0;

  int   ready_mode = 0;
  logic ready_fix  = 1'b1;

  data_memory_dump_ctrl dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_start(start_a), .i_mem_data(mem_data_a),
    .o_mem_pointer(ptr_a), .o_tx_data(tx_data_a), .o_tx_valid(valid_a),
    .i_tx_ready(tx_ready_a), .o_busy(busy_a), .o_done(done_a)
  );

  data_memory_dump_ctrl #(.NUM_WORDS(1), .READ_LATENCY(3)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_start(start_b), .i_mem_data(mem_data_b),
    .o_mem_pointer(ptr_b), .o_tx_data(tx_data_b), .o_tx_valid(valid_b),
    .i_tx_ready(ready_b), .o_busy(busy_b), .o_done(done_b)
  );

  // Memory models: one-cycle read port for A, three-stage read port for B.
  always @(posedge clk) mem_data_a <= mem[ptr_a];
  always @(posedge clk) begin
    pipe_b1 <= (ptr_b == 7'd0) ? 32'hDEADBEEF : 32'h0000_0000;
    pipe_b2 <= pipe_b1;
    pipe_b3 <= pipe_b2;
  end
  assign mem_data_b = pipe_b3;

  // Ready driver for A: fixed level or ~30% random, updated after each edge.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) tx_ready_a = ($urandom_range(0, 9) < 3);
    else                 tx_ready_a = ready_fix;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_dump_a();
    for (int k = 0; k < 128; k++) begin
      exp_q.push_back(mem[k][31:24]);
      exp_q.push_back(mem[k][23:16]);
      exp_q.push_back(mem[k][15:8]);
      exp_q.push_back(mem[k][7:0]);
    end
  endtask

  // Monitor A: scoreboard pop, hold-under-stall and pointer-step checks.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [6:0] prev_ptr;
    logic       prev_busy;
    logic [7:0] b;
    prev_stall = 1'b0; prev_busy = 1'b0; prev_data = 8'd0; prev_ptr = 7'd0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {31'd0, valid_a}, 32'd1);
          check("hold_data", {24'd0, tx_data_a}, {24'd0, prev_data});
        end
        if (valid_a && tx_ready_a) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data_a);
          end else begin
            b = exp_q.pop_front();
            check("byte_a", {24'd0, tx_data_a}, {24'd0, b});
          end
          bytes_a++;
        end
        if (done_a) done_cnt_a++;
        if (busy_a && prev_busy && (ptr_a != prev_ptr))
          check("ptr_step", {25'd0, ptr_a}, 32'(prev_ptr) + 32'd1);
        prev_stall = valid_a && !tx_ready_a;
        prev_data  = tx_data_a;
        prev_ptr   = ptr_a;
        prev_busy  = busy_a;
      end
    end
  end

  // Monitor B: scoreboard pop and pointer pinned at word 0.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (valid_b && ready_b) begin
          if (exp_qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte_b: got %0h, expected no byte", tx_data_b);
          end else begin
            b = exp_qb.pop_front();
            check("byte_b", {24'd0, tx_data_b}, {24'd0, b});
          end
          bytes_b++;
        end
        if (done_b) done_cnt_b++;
        if (busy_b) check("ptr_b_zero", {25'd0, ptr_b}, 32'd0);
      end
    end
  end

  // Pulse start on A, optionally re-pulse mid-dump, and time the dump.
  task automatic run_a(input int exp_done_n, input int exp_valid_n,
                       input int restart_at, input int bound);
    int n;
    int first_v;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    first_v = -1;
    while (!done_a && n < bound) begin
      start_a = (n == restart_at);
      if (valid_a && first_v < 0) begin
        first_v = n;
        check("first_ptr", {25'd0, ptr_a}, 32'd0);
      end
      @(posedge clk); #1; n++;
    end
    start_a = 1'b0;
    if (!done_a) begin
      checks++;
      errors++;
      $display("FAIL done_timeout_a: got no done after %0d cycles, expected done", n);
    end
    if (exp_done_n >= 0) check("done_cycle", n, exp_done_n);
    if (exp_valid_n >= 0) check("valid_rise", first_v, exp_valid_n);
    @(posedge clk); #1;
    check("busy_after_done", {31'd0, busy_a}, 32'd0);
    check("done_one_cycle", {31'd0, done_a}, 32'd0);
  endtask

  initial begin
    int base_b, base_d, n;
    for (int k = 0; k < 128; k++) mem[k] = 32'hA500_0000 | k;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;

    // Reset values, then idle with no start.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ptr", {25'd0, ptr_a}, 32'd0);
    check("rst_data", {24'd0, tx_data_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_busy", {31'd0, busy_a}, 32'd0);
      check("idle_valid", {31'd0, valid_a}, 32'd0);
    end

    // Full dump without backpressure: 128 words * 6 cycles.
    base_b = bytes_a; base_d = done_cnt_a;
    push_dump_a();
    run_a(768, 2, -1, 2000);
    check("full_bytes", bytes_a - base_b, 512);
    check("full_dones", done_cnt_a - base_d, 1);
    check("full_queue_empty", exp_q.size(), 0);

    // Random backpressure, first word 12345678.
    mem[0] = 32'h1234_5678;
    base_b = bytes_a; base_d = done_cnt_a;
    push_dump_a();
    ready_mode = 1;
    run_a(-1, -1, -1, 20000);
    ready_mode = 0;
    check("bp_bytes", bytes_a - base_b, 512);
    check("bp_dones", done_cnt_a - base_d, 1);
    check("bp_queue_empty", exp_q.size(), 0);

    // Second start while busy is ignored.
    base_b = bytes_a; base_d = done_cnt_a;
    push_dump_a();
    run_a(768, 2, 100, 2000);
    repeat (20) @(posedge clk);
    #1;
    check("rs_bytes", bytes_a - base_b, 512);
    check("rs_dones", done_cnt_a - base_d, 1);
    check("rs_idle_busy", {31'd0, busy_a}, 32'd0);

    // Boundary instance: one word, three-cycle read latency.
    exp_qb.push_back(8'hDE); exp_qb.push_back(8'hAD);
    exp_qb.push_back(8'hBE); exp_qb.push_back(8'hEF);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0; base_b = -1;
    while (!done_b && n < 100) begin
      if (valid_b && base_b < 0) base_b = n;
      @(posedge clk); #1; n++;
    end
    check("b_valid_rise", base_b, 4);
    check("b_done_cycle", n, 8);
    @(posedge clk); #1;
    check("b_busy_after", {31'd0, busy_b}, 32'd0);
    check("b_bytes", bytes_b, 4);
    check("b_dones", done_cnt_b, 1);

    // Reset mid-dump after 37 bytes, then a clean restart from word 0.
    base_b = bytes_a;
    push_dump_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while ((bytes_a - base_b) < 37 && n < 1000) begin
      @(negedge clk); n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, valid_a}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst_ptr", {25'd0, ptr_a}, 32'd0);
    check("mid_rst_done", {31'd0, done_a}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    base_b = bytes_a; base_d = done_cnt_a;
    push_dump_a();
    run_a(768, 2, -1, 2000);
    check("restart_bytes", bytes_a - base_b, 512);
    check("restart_dones", done_cnt_a - base_d, 1);
    check("restart_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_dump_ctrl.md
Name: data_memory_dump_ctrl

Overview:
- Debug-side sequencer for the data memory debug read port.
- On a start request from the debug unit, walks the debug pointer from word 0 to NUM_WORDS-1 and reads each 32-bit word.
- Streams each word to the UART transmitter as 4 bytes, MSB first, over a valid/ready handshake, then signals completion.
- Sits between the debug unit, the memory-access stage debug port (pointer in, read word out) and the UART TX.

Parameters:
- TAM_DATA, 32: memory word width; fixed at 32 (4 bytes per word).
- NUM_DIREC, 7: debug pointer width.
- NUM_WORDS, 128: words dumped; range 1..2^NUM_DIREC.
- READ_LATENCY, 1: cycles from pointer change to valid i_mem_data; range 1..4.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  dump request; level-sampled in IDLE only.
- i_mem_data  in  TAM_DATA  word from data memory debug read port.
- o_mem_pointer  out  NUM_DIREC  word address to data memory debug port.
- o_tx_data  out  8  byte to UART TX.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  UART TX can accept a byte.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse when the last byte has been accepted.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - state IDLE.
  - o_mem_pointer=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
  - Word register, byte index and latency counter all 0.
- All outputs are registered.
- States: IDLE, ADDR, LOAD, SEND, DONE.
- IDLE:
  - o_busy=0.
  - i_start=1 at an edge -> ADDR, o_mem_pointer=0, o_busy=1, latency counter=0.
- ADDR:
  - Pointer held stable.
  - Counter increments each cycle.
  - After READ_LATENCY cycles in ADDR -> LOAD.
- LOAD:
  - Latch i_mem_data into the word register; byte index=0.
  - Next state SEND with o_tx_valid=1 and o_tx_data=word[31:24].
- SEND:
  - A transfer occurs at an edge where o_tx_valid=1 and i_tx_ready=1.
  - Until a transfer occurs, o_tx_data and o_tx_valid are held unchanged; o_tx_valid never drops without a transfer.
  - Byte order: idx0=[31:24], idx1=[23:16], idx2=[15:8], idx3=[7:0].
  - Transfer with idx<3: idx+1 and the next byte is presented in the following cycle, so back-to-back transfers are possible.
  - Transfer with idx=3:
    - If o_mem_pointer==NUM_WORDS-1: o_tx_valid=0 -> DONE.
    - Otherwise: o_tx_valid=0, o_mem_pointer+1 -> ADDR.
- DONE:
  - o_done=1 for exactly one cycle; o_busy still 1.
  - o_mem_pointer is then reset to 0 -> IDLE.
  - o_done is 0 in every other state.
- Timing:
  - With start sampled at edge E, o_tx_valid rises at edge E+READ_LATENCY+1.
  - Per word, with i_tx_ready held at 1: READ_LATENCY+5 cycles.
  - Whole dump: NUM_WORDS*(READ_LATENCY+5) cycles, plus 1 DONE cycle.
- Boundary and corner cases:
  - o_mem_pointer never exceeds NUM_WORDS-1 and never wraps during a dump.
  - i_start while o_busy=1 is ignored (no restart, no queueing).
  - i_start held high through DONE starts a new dump from IDLE on the edge after DONE.
  - i_tx_ready high while o_tx_valid=0 causes no transfer.
  - i_tx_ready may toggle arbitrarily; a byte is never skipped or duplicated.
  - NUM_WORDS=1: a single word, then DONE.
  - Reset asserted mid-dump aborts immediately: all outputs go to reset values and the partial dump is discarded.
- The block never writes memory; it only drives the debug pointer.

Test Plan:
1. Reset values: assert i_reset=0 mid-SEND -> o_tx_valid=0, o_busy=0, o_mem_pointer=0 with no clock edge. Release, wait 10 cycles with i_start=0 -> no activity.
2. Full dump, no backpressure: mem[k]=0xA5000000|k, i_tx_ready=1, pulse i_start -> 512 bytes A5,00,00,00, A5,00,00,01 ... A5,00,00,7F; o_done pulses once at cycle 768+1 after first valid-phase timing per formula; o_busy falls the next cycle.
3. Backpressure: i_tx_ready random (~30% high), mem[0]=0x12345678 -> byte stream begins 12,34,56,78; o_tx_data is stable while valid && !ready; total accepted bytes = 512.
4. Start while busy: second i_start pulse mid-dump -> exactly 512 bytes total and one o_done; o_mem_pointer sequence is monotonic 0..127.
5. Boundary parameters: NUM_WORDS=1 and READ_LATENCY=3, mem[0]=0xDEADBEEF -> o_tx_valid rises 4 edges after start; bytes DE,AD,BE,EF; o_done pulses; o_mem_pointer never leaves 0.
6. Reset mid-dump: reset after 37 bytes, then restart -> the dump restarts at pointer 0 and the first byte equals mem[0][31:24].
